regfile_sb: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and an integrated per-register scoreboard for the pipelined CPU. It sits in the ID stage: decode issues destination registers (marking them pending), WB writes results (clearing pending), and each read port returns registered data plus a ready flag so hazard logic can stall without a separate scoreboard.

---
 rtl/regfile_sb.sv | 125 ++++++++++++
 tb/tb_regfile_sb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-first bypass and an
// integrated per-register pending scoreboard. Every output is registered;
// read data and ready flags reflect the state after the current edge's
// writeback/issue activity, so hazard logic never sees a stale operand.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     Rw,
    input  logic [DATA_W-1:0]     busW,
    input  logic                  Iss,
    input  logic [ADDR_W-1:0]     Rd,
    input  logic [NRD*ADDR_W-1:0] Ra,
    output logic [NRD*DATA_W-1:0] busR,
    output logic [NRD-1:0]        Rdy,
    output logic [ADDR_W:0]       PendCnt
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    // Pending count of a scoreboard vector; ADDR_W+1 bits holds DEPTH exactly.
    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              wr_en;
    logic              iss_en;

    logic [ADDR_W-1:0] ra_port  [NRD];
    logic [DATA_W-1:0] rd_data_nxt [NRD];
    logic [NRD-1:0]    rdy_nxt;

    // Register 0 is hard-wired when ZERO_EN: it is never written and never
    // becomes pending, so both enables are masked for address 0.
    assign wr_en  = WE  && !(ZERO_EN && (Rw == '0));
    assign iss_en = Iss && !(ZERO_EN && (Rd == '0));

    genvar g;
    generate
        for (g = 0; g < NRD; g++) begin : g_port_addr
            assign ra_port[g] = Ra[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scoreboard next state: writeback clears first, then issue sets, so a
    // same-cycle issue to the written register leaves it pending (new producer).
    always_comb begin
        pend_nxt = pend;
        if (WE) begin
            pend_nxt[Rw] = 1'b0;
        end
        if (iss_en) begin
            pend_nxt[Rd] = 1'b1;
        end
    end

    // Per-port read selection: zero register, then writeback bypass, then array.
    always_comb begin
        rd_data_nxt = '{default: '0};
        rdy_nxt     = '1;
        for (int k = 0; k < NRD; k++) begin
            if (ZERO_EN && (ra_port[k] == '0)) begin
                rd_data_nxt[k] = '0;
                rdy_nxt[k]     = 1'b1;
            end else begin
                if (WE && (Rw == ra_port[k])) begin
                    rd_data_nxt[k] = busW;
                end else begin
                    rd_data_nxt[k] = regs[ra_port[k]];
                end
                rdy_nxt[k] = ~pend_nxt[ra_port[k]];
            end
        end
    end

    // Register array storage; cleared by reset, written on enabled writeback.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[Rw] <= busW;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend    <= '0;
            PendCnt <= '0;
        end else begin
            pend    <= pend_nxt;
            PendCnt <= popcount(pend_nxt);
        end
    end

    // Registered read ports: data and ready flag for each port.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busR <= '0;
            Rdy  <= '1;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                busR[k*DATA_W +: DATA_W] <= rd_data_nxt[k];
            end
            Rdy <= rdy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb plus hand-written
// sequences for asynchronous reset and scoreboard saturation.
module tb_regfile_sb;

    logic        Clk;
    logic        Rst_n;
    logic        WE;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        Iss;
    logic [4:0]  Rd;
    logic [9:0]  Ra;
    logic [63:0] busR;
    logic [1:0]  Rdy;
    logic [5:0]  PendCnt;
    logic [63:0] s_busR;
    logic [1:0]  s_Rdy;
    logic [5:0]  s_PendCnt;

    int n_pass = 0;
    int n_total = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .Rw(Rw), .busW(busW), .Iss(Iss),
        .Rd(Rd), .Ra(Ra), .busR(busR), .Rdy(Rdy), .PendCnt(PendCnt)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0)) u_sat (
        .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .Rw(Rw), .busW(busW), .Iss(Iss),
        .Rd(Rd), .Ra(Ra), .busR(s_busR), .Rdy(s_Rdy), .PendCnt(s_PendCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        iss;
        logic [4:0]  rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // r3 bypass, r0 hard-wired, r4 issue/writeback, r9 issue+wb same cycle,
        // r7 wb to idle reg and re-issue, r5/r6 setup for the reset test
        vecs[0]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 2'b11, 6'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 2'b11, 6'd0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h12345678, 2'b11, 6'd0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0,        2'b10, 6'd1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd3, 32'h0,        32'h12345678, 2'b10, 6'd1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 32'h0,        32'h0,        2'b00, 6'd1};
        vecs[6]  = '{1'b1, 5'd4, 32'hA5,       1'b0, 5'd0, 5'd4, 5'd0, 32'hA5,       32'h0,        2'b11, 6'd0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd4, 32'h0,        32'hA5,       2'b10, 6'd1};
        vecs[8]  = '{1'b1, 5'd9, 32'h55,       1'b1, 5'd9, 5'd9, 5'd9, 32'h55,       32'h55,       2'b00, 6'd1};
        vecs[9]  = '{1'b1, 5'd9, 32'h66,       1'b0, 5'd0, 5'd9, 5'd2, 32'h66,       32'h0,        2'b11, 6'd0};
        vecs[10] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 5'd7, 5'd7, 32'h77,       32'h77,       2'b00, 6'd1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd8, 32'h77,       32'h0,        2'b10, 6'd1};
        vecs[12] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        2'b01, 6'd2};

        Rst_n = 1'b0; WE = 1'b0; Rw = '0; busW = '0; Iss = 1'b0; Rd = '0; Ra = '0;
        repeat (2) step();
        chk("reset_busR", busR, 64'h0);
        chk("reset_rdy", {62'b0, Rdy}, 64'h3);
        chk("reset_cnt", {58'b0, PendCnt}, 64'h0);
        Rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            WE = vecs[i].we; Rw = vecs[i].rw; busW = vecs[i].busw;
            Iss = vecs[i].iss; Rd = vecs[i].rd; Ra = {vecs[i].ra1, vecs[i].ra0};
            step();
            chk($sformatf("v%0d_d0", i), {32'b0, busR[31:0]}, {32'b0, vecs[i].d0});
            chk($sformatf("v%0d_d1", i), {32'b0, busR[63:32]}, {32'b0, vecs[i].d1});
            chk($sformatf("v%0d_rdy", i), {62'b0, Rdy}, {62'b0, vecs[i].rdy});
            chk($sformatf("v%0d_cnt", i), {58'b0, PendCnt}, {58'b0, vecs[i].cnt});
        end

        // Asynchronous reset mid-cycle with a write and an issue in flight
        WE = 1'b1; Rw = 5'd5; busW = 32'hDEADBEEF; Iss = 1'b1; Rd = 5'd7; Ra = {5'd6, 5'd5};
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_busR", busR, 64'h0);
        chk("async_rdy", {62'b0, Rdy}, 64'h3);
        chk("async_cnt", {58'b0, PendCnt}, 64'h0);
        step();
        Rst_n = 1'b1;
        WE = 1'b0; Iss = 1'b0; Ra = {5'd7, 5'd5};
        step();
        chk("post_rst_r5", {32'b0, busR[31:0]}, 64'h0);
        chk("post_rst_r7", {32'b0, busR[63:32]}, 64'h0);
        chk("post_rst_rdy", {62'b0, Rdy}, 64'h3);
        chk("post_rst_cnt", {58'b0, PendCnt}, 64'h0);

        // Saturation: issue every register once
        Ra = {5'd1, 5'd0};
        for (int i = 0; i < 32; i++) begin
            Iss = 1'b1; Rd = i[4:0];
            step();
            if (i == 15) chk("sat_half_cnt", {58'b0, s_PendCnt}, 64'd16);
        end
        chk("sat_full_cnt", {58'b0, s_PendCnt}, 64'd32);
        chk("sat_full_rdy", {62'b0, s_Rdy}, 64'h0);
        chk("z_full_cnt", {58'b0, PendCnt}, 64'd31);
        chk("z_full_rdy", {62'b0, Rdy}, 64'h1);

        Rd = 5'd1;
        step();
        chk("sat_reissue_cnt", {58'b0, s_PendCnt}, 64'd32);
        chk("z_reissue_cnt", {58'b0, PendCnt}, 64'd31);

        Iss = 1'b0; WE = 1'b1; Rw = 5'd1; busW = 32'h1111; Ra = {5'd0, 5'd1};
        step();
        chk("sat_wb_cnt", {58'b0, s_PendCnt}, 64'd31);
        chk("sat_wb_d0", {32'b0, s_busR[31:0]}, 64'h1111);
        chk("sat_wb_rdy", {62'b0, s_Rdy}, 64'h1);
        chk("z_wb_cnt", {58'b0, PendCnt}, 64'd30);

        Rw = 5'd0; busW = 32'hCAFE; Ra = {5'd0, 5'd0};
        step();
        chk("sat_r0_data", s_busR, {32'hCAFE, 32'hCAFE});
        chk("sat_r0_rdy", {62'b0, s_Rdy}, 64'h3);
        chk("sat_r0_cnt", {58'b0, s_PendCnt}, 64'd30);
        chk("z_r0_data", busR, 64'h0);
        chk("z_r0_cnt", {58'b0, PendCnt}, 64'd30);

        WE = 1'b0;
        step();
        chk("sat_r0_hold", {32'b0, s_busR[31:0]}, 64'hCAFE);
        chk("z_r0_hold", {32'b0, busR[31:0]}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
